mmio_stream_fifo: RTL
=====================

# mmio_stream_fifo

Circular-buffer FIFO between the AFU's MMIO write decode and its MMIO read-response logic. Host MMIO writes to the data register push 64-bit words. Host MMIO reads of the same register pop the oldest word and return it, registered, in time for the read-response stage. Occupancy and sticky error flags are exported so the AFU can map them to a status CSR.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2
- WIDTH, 64, data word width in bits

Ports:
- clk  in  1  sole clock; all logic is synchronous to its rising edge
- rst  in  1  asynchronous, active-high reset
- push  in  1  one-cycle strobe: a decoded MMIO write hit the data address
- push_data  in  WIDTH  write payload, sampled when push=1
- pop  in  1  one-cycle strobe: a decoded MMIO read hit the data address
- pop_data  out  WIDTH  read payload, valid when pop_data_valid=1
- pop_data_valid  out  1  one-cycle pulse, exactly one cycle after every pop
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  out  1  count==DEPTH
- empty  out  1  count==0
- overflow  out  1  sticky: a push was dropped because the FIFO was full
- underflow  out  1  sticky: a pop found the FIFO empty
- clr_err  in  1  clears overflow and underflow

## Operation
- Storage: DEPTH×WIDTH array, write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH through natural overflow. A separate count register is kept; full and empty are decoded from count, not from pointer compare.
- Push, not full: mem[wr_ptr]<=push_data, wr_ptr++, count++.
- Push, full, no pop in the same cycle: the word is dropped, overflow<=1, pointers and count are unchanged.
- Pop, not empty: pop_data<=mem[rd_ptr], rd_ptr++, count--.
- Pop, empty: pop_data<=0, underflow<=1, rd_ptr is unchanged. pop_data_valid still pulses, because every MMIO read needs a response.
- Push and pop together, 0<count<DEPTH: both are performed, count is unchanged.
- Push and pop together, full: both are performed. The pop returns the oldest word, the push writes into the freed slot, count stays DEPTH, overflow is not set.
- Push and pop together, empty: the pop is an underflow (returns 0, sets underflow). The push is accepted and count becomes 1. The popped value is never the same-cycle push_data.
- clr_err=1 clears both sticky flags. If an error occurs in the same cycle as clr_err, setting wins.
- Entry contents are not reset. Only pointers, count, flags and outputs are reset.

## Timing
- Reset values: pop_data=0, pop_data_valid=0, count=0, full=0, empty=1, overflow=0, underflow=0, wr_ptr=rd_ptr=0.
- If rst asserts mid-operation, all state clears immediately. A pop_data_valid that was pending is lost.
- Pop latency is 1 cycle: pop at edge N gives pop_data and pop_data_valid at edge N+1. pop_data holds its value until the next pop.
- count, full and empty are registered and reflect the operations of the previous edge.
- Throughput is 1 push and 1 pop per cycle, sustained.
- No backpressure: push and pop are always accepted at the interface, and errors are reported only through the sticky flags.

## Structure
- Package afu_fifo_pkg holds:
  - FIFO_DEPTH=8 and FIFO_WIDTH=64 defaults
  - MMIO addresses: FIFO_DATA_ADDR=16'h0020 and FIFO_STAT_ADDR=16'h0022
  - packed struct t_fifo_status {overflow, underflow, full, empty, count}, used by the AFU to form the status CSR
- No sub-module: storage, pointers and flags form a single always_ff plus output assigns.

## Test plan
- Reset, then push 0x11,0x22,0x33, then pop ×3 -> pop_data 0x11,0x22,0x33 on the cycle after each pop; count steps 3→0; empty=1 at the end.
- Push DEPTH words 0..7, then push 0xDEAD -> full=1, overflow=1, count=8; popping all 8 returns 0..7 and 0xDEAD never appears.
- Fill to full, then assert push 0xAA and pop together -> pop returns word 0, count stays 8, overflow stays 0; after 8 more pops the last value out is 0xAA.
- Pop when empty -> pop_data=0, pop_data_valid=1, underflow=1; then pulse clr_err -> underflow=0.
- Wrap-around: run 20 push/pop pairs with data i -> pops return 0..19 in order; pointers wrap twice; count never exceeds 1.
- Assert rst for one cycle with count=5 and a pop in flight -> all outputs at reset values next cycle; a following push 0x5 then pop returns 0x5.

Source files
------------

// File: rtl/afu_fifo_pkg.sv
// Shared definitions for the AFU MMIO stream FIFO: default geometry,
// register addresses and the status word layout used by the status CSR.
package afu_fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_WIDTH = 64;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [15:0] FIFO_DATA_ADDR = 16'h0020;
  localparam logic [15:0] FIFO_STAT_ADDR = 16'h0022;

  typedef struct packed {
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic [FIFO_CNT_W-1:0] count;
  } t_fifo_status;

endpackage

// File: rtl/mmio_stream_fifo.sv
// Circular-buffer FIFO between MMIO write decode and MMIO read response.
// Pops always produce a registered response one cycle later, even when empty.
module mmio_stream_fifo
  import afu_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_data_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             push_drop;
  logic             pop_miss;

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != FULL_COUNT) || pop);
  assign push_drop = push && (count == FULL_COUNT) && !pop;
  assign pop_miss  = pop && (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      pop_data       <= '0;
      pop_data_valid <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      pop_data_valid <= pop;

      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end

      if (do_pop) begin
        pop_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end else if (pop_miss) begin
        pop_data <= '0;
      end

      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end

      // An error in the same cycle as clr_err must not be lost.
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end

      if (pop_miss) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule
